// File: rtl/sel_decode_pipe.sv
// Operand-select decode stage: one-hot class code -> select lookup, illegal-code
// flagging with a saturating error counter, and a 2-entry skid FIFO on the output.
module sel_decode_pipe #(
    parameter int                        NCLASS      = 10,
    parameter int                        NSEL        = 1,
    parameter logic [NCLASS*NSEL-1:0]    SEL_TABLE   = 10'b1111001111,
    parameter logic [NSEL-1:0]           ILLEGAL_SEL = {NSEL{1'b0}},
    parameter int                        ERR_W       = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [NCLASS-1:0] in_code,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [NSEL-1:0]   out_sel,
    output logic [NCLASS-1:0] out_code,
    output logic              out_illegal,
    input  logic              flush,
    input  logic              err_clr,
    output logic [ERR_W-1:0]  err_cnt
);

    localparam logic [ERR_W-1:0] ERR_MAX = {ERR_W{1'b1}};
    localparam logic [ERR_W-1:0] ERR_ONE = {{(ERR_W-1){1'b0}}, 1'b1};

    // True when exactly one bit of the code is set.
    function automatic logic is_one_hot(input logic [NCLASS-1:0] code);
        logic seen;
        logic multi;
        seen  = 1'b0;
        multi = 1'b0;
        for (int i = 0; i < NCLASS; i++) begin
            multi = multi | (seen & code[i]);
            seen  = seen | code[i];
        end
        return seen & ~multi;
    endfunction

    // OR of the table rows selected by the code; meaningful only for one-hot codes.
    function automatic logic [NSEL-1:0] lookup_sel(input logic [NCLASS-1:0] code);
        logic [NSEL-1:0] sel;
        sel = {NSEL{1'b0}};
        for (int i = 0; i < NCLASS; i++) begin
            sel = sel | (SEL_TABLE[i*NSEL +: NSEL] & {NSEL{code[i]}});
        end
        return sel;
    endfunction

    logic [NSEL-1:0]   mem_sel_r  [2];
    logic [NCLASS-1:0] mem_code_r [2];
    logic              mem_ill_r  [2];
    logic              wr_ptr_r;
    logic              rd_ptr_r;
    logic [1:0]        count_r;
    logic [ERR_W-1:0]  err_cnt_r;

    logic [NSEL-1:0]   dec_sel_s;
    logic              dec_ill_s;
    logic              push_s;
    logic              pop_s;

    assign in_ready  = (count_r != 2'd2);
    assign out_valid = (count_r != 2'd0);
    assign push_s    = in_valid & in_ready & ~flush;
    assign pop_s     = out_valid & out_ready & ~flush;
    assign err_cnt   = err_cnt_r;

    // Combinational decode of the incoming class code.
    always_comb begin
        dec_sel_s = ILLEGAL_SEL;
        dec_ill_s = 1'b1;
        if (is_one_hot(in_code)) begin
            dec_sel_s = lookup_sel(in_code);
            dec_ill_s = 1'b0;
        end else begin
            dec_sel_s = ILLEGAL_SEL;
            dec_ill_s = 1'b1;
        end
    end

    // FIFO storage, pointers and occupancy; flush voids both handshakes.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_r      <= 1'b0;
            rd_ptr_r      <= 1'b0;
            count_r       <= 2'd0;
            mem_sel_r[0]  <= {NSEL{1'b0}};
            mem_sel_r[1]  <= {NSEL{1'b0}};
            mem_code_r[0] <= {NCLASS{1'b0}};
            mem_code_r[1] <= {NCLASS{1'b0}};
            mem_ill_r[0]  <= 1'b0;
            mem_ill_r[1]  <= 1'b0;
        end else if (flush) begin
            wr_ptr_r <= 1'b0;
            rd_ptr_r <= 1'b0;
            count_r  <= 2'd0;
        end else begin
            if (push_s) begin
                mem_sel_r[wr_ptr_r]  <= dec_sel_s;
                mem_code_r[wr_ptr_r] <= in_code;
                mem_ill_r[wr_ptr_r]  <= dec_ill_s;
                wr_ptr_r             <= ~wr_ptr_r;
            end
            if (pop_s) begin
                rd_ptr_r <= ~rd_ptr_r;
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + 2'd1;
                2'b01:   count_r <= count_r - 2'd1;
                default: count_r <= count_r;
            endcase
        end
    end

    // Saturating count of accepted illegal codes; clear beats increment.
    always_ff @(posedge clk) begin
        if (reset) begin
            err_cnt_r <= {ERR_W{1'b0}};
        end else if (err_clr) begin
            err_cnt_r <= {ERR_W{1'b0}};
        end else if (push_s && dec_ill_s && (err_cnt_r != ERR_MAX)) begin
            err_cnt_r <= err_cnt_r + ERR_ONE;
        end
    end

    // Head entry presented downstream, forced to zero while empty.
    always_comb begin
        out_sel     = {NSEL{1'b0}};
        out_code    = {NCLASS{1'b0}};
        out_illegal = 1'b0;
        if (count_r != 2'd0) begin
            out_sel     = mem_sel_r[rd_ptr_r];
            out_code    = mem_code_r[rd_ptr_r];
            out_illegal = mem_ill_r[rd_ptr_r];
        end else begin
            out_sel     = {NSEL{1'b0}};
            out_code    = {NCLASS{1'b0}};
            out_illegal = 1'b0;
        end
    end

endmodule
